// File: rtl/sccb_reg_sequencer.sv
// SCCB register sequencer: walks a register LUT and issues one SCCB
// write per entry, with delay entries, end marker, NACK retry and restart.
`timescale 1ns/1ps
module sccb_reg_sequencer #(
    parameter int INDEX_W      = 8,
    parameter int LUT_BASE     = 2,
    parameter int LUT_SIZE     = 4,
    parameter int TICKS_PER_MS = 25000,
    parameter int MAX_RETRY    = 3,
    parameter int AUTO_START   = 1
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iSTART,
    input  logic [7:0]         iSLAVE_ADDR,
    output logic [INDEX_W-1:0] LUT_INDEX,
    input  logic [15:0]        LUT_DATA,
    output logic               oREQ,
    output logic [7:0]         oDEV_ADDR,
    output logic [7:0]         oREG_ADDR,
    output logic [7:0]         oREG_DATA,
    input  logic               iACK,
    input  logic               iNACK,
    output logic               oBUSY,
    output logic               oDONE,
    output logic               oERR,
    output logic [INDEX_W-1:0] oERR_INDEX
);

    localparam int DLY_W = $clog2(TICKS_PER_MS * 255 + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    localparam logic [INDEX_W-1:0] FIRST = INDEX_W'(LUT_BASE);
    localparam logic [INDEX_W-1:0] LAST  = INDEX_W'(LUT_BASE + LUT_SIZE - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_ISSUE  = 4'd3;
    localparam logic [3:0] S_WAIT   = 4'd4;
    localparam logic [3:0] S_DELAY  = 4'd5;
    localparam logic [3:0] S_NEXT   = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_FAIL   = 4'd8;

    logic [3:0]       state;
    logic [DLY_W-1:0] delay_cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic             is_end;
    logic             is_delay;
    logic [DLY_W-1:0] delay_len;
    logic             launch;

    // Classify the current LUT word and size a delay entry in clock ticks.
    always_comb begin
        is_end    = (LUT_DATA == 16'hFFFF);
        is_delay  = (LUT_DATA[15:8] == 8'hFF);
        delay_len = DLY_W'(TICKS_PER_MS) * DLY_W'(LUT_DATA[7:0]);
        launch    = iSTART || (state == S_IDLE && AUTO_START != 0);
    end

    // Sequencer FSM; the delay counter spans DELAY entry to the next FETCH.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= S_IDLE;
            LUT_INDEX  <= FIRST;
            oREQ       <= 1'b0;
            oDEV_ADDR  <= 8'h00;
            oREG_ADDR  <= 8'h00;
            oREG_DATA  <= 8'h00;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
            oERR       <= 1'b0;
            oERR_INDEX <= '0;
            delay_cnt  <= '0;
            retry_cnt  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (launch) begin
                        oDONE     <= 1'b0;
                        oERR      <= 1'b0;
                        retry_cnt <= '0;
                        LUT_INDEX <= FIRST;
                        if (LUT_SIZE == 0) begin
                            oDONE <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            oBUSY <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    if (is_end) begin
                        oDONE <= 1'b1;
                        oBUSY <= 1'b0;
                        state <= S_DONE;
                    end else if (is_delay) begin
                        if (LUT_DATA[7:0] == 8'h00) begin
                            state <= S_NEXT;
                        end else begin
                            delay_cnt <= delay_len - DLY_W'(1);
                            state     <= S_DELAY;
                        end
                    end else begin
                        oDEV_ADDR <= iSLAVE_ADDR;
                        oREG_ADDR <= LUT_DATA[15:8];
                        oREG_DATA <= LUT_DATA[7:0];
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    oREQ  <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (iNACK) begin
                        oREQ <= 1'b0;
                        if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RTY_W'(1);
                            state     <= S_ISSUE;
                        end else begin
                            oERR_INDEX <= LUT_INDEX;
                            oERR       <= 1'b1;
                            oBUSY      <= 1'b0;
                            state      <= S_FAIL;
                        end
                    end else if (iACK) begin
                        oREQ      <= 1'b0;
                        retry_cnt <= '0;
                        state     <= S_NEXT;
                    end
                end
                S_DELAY: begin
                    if (delay_cnt <= DLY_W'(1)) begin
                        delay_cnt <= '0;
                        state     <= S_NEXT;
                    end else begin
                        delay_cnt <= delay_cnt - DLY_W'(1);
                    end
                end
                S_NEXT: begin
                    if (LUT_INDEX == LAST) begin
                        oDONE <= 1'b1;
                        oBUSY <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        LUT_INDEX <= LUT_INDEX + INDEX_W'(1);
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_reg_sequencer.sv
// Directed bench for sccb_reg_sequencer: LUT model, SCCB responder,
// write monitor and one task per scenario.
`timescale 1ns/1ps
module tb_sccb_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        b_start = 1'b0;
    logic [7:0]  slave_addr = 8'h42;
    logic [7:0]  lut_index;
    logic [15:0] lut_data;
    logic        req;
    logic [7:0]  dev_addr, reg_addr, reg_data;
    logic        ack = 1'b0;
    logic        nack = 1'b0;
    logic        busy, done, err;
    logic [7:0]  err_index;

    logic [7:0]  b_index, b_dev, b_reg, b_dat, b_err_index;
    logic        b_req, b_busy, b_done, b_err;

    logic [15:0] lut_mem [0:15];

    int vectors = 0;
    int miscompares = 0;

    // responder configuration
    int          ack_delay = 10;
    logic [7:0]  nack_idx = 8'hFF;
    int          nack_left = 0;
    bit          nack_forever = 0;
    logic [7:0]  both_idx = 8'hFF;
    int          both_left = 0;
    logic [7:0]  hold_idx = 8'hFF;

    // monitor state
    int          cyc = 0;
    logic        req_q = 1'b0;
    logic [7:0]  idx_q = 8'h00;
    int          fall_cyc = 0;
    bit          had_fall = 0;
    int          min_gap = 1000;
    logic [7:0]  w_idx [$];
    logic [23:0] w_word [$];
    int          chg_cyc [16];

    assign lut_data = (lut_index < 8'd16) ? lut_mem[lut_index[3:0]] : 16'hFFFF;

    always #5 clk = ~clk;

    sccb_reg_sequencer #(
        .INDEX_W(8), .LUT_BASE(2), .LUT_SIZE(4),
        .TICKS_PER_MS(10), .MAX_RETRY(3), .AUTO_START(1)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start),
        .iSLAVE_ADDR(slave_addr), .LUT_INDEX(lut_index),
        .LUT_DATA(lut_data), .oREQ(req), .oDEV_ADDR(dev_addr),
        .oREG_ADDR(reg_addr), .oREG_DATA(reg_data),
        .iACK(ack), .iNACK(nack), .oBUSY(busy), .oDONE(done),
        .oERR(err), .oERR_INDEX(err_index)
    );

    sccb_reg_sequencer #(
        .INDEX_W(8), .LUT_BASE(2), .LUT_SIZE(0),
        .TICKS_PER_MS(10), .MAX_RETRY(3), .AUTO_START(0)
    ) dut_empty (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(b_start),
        .iSLAVE_ADDR(slave_addr), .LUT_INDEX(b_index),
        .LUT_DATA(16'h1280), .oREQ(b_req), .oDEV_ADDR(b_dev),
        .oREG_ADDR(b_reg), .oREG_DATA(b_dat),
        .iACK(1'b0), .iNACK(1'b0), .oBUSY(b_busy), .oDONE(b_done),
        .oERR(b_err), .oERR_INDEX(b_err_index)
    );

    // Log every oREQ rising edge and every LUT_INDEX change.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (req && !req_q) begin
            w_idx.push_back(lut_index);
            w_word.push_back({dev_addr, reg_addr, reg_data});
            if (had_fall && (cyc - fall_cyc) < min_gap)
                min_gap = cyc - fall_cyc;
        end
        if (!req && req_q) begin
            fall_cyc = cyc;
            had_fall = 1;
        end
        if (lut_index != idx_q)
            chg_cyc[lut_index[3:0]] = cyc;
        req_q = req;
        idx_q = lut_index;
    end

    // SCCB master model: answers each request after ack_delay cycles.
    initial begin
        bit abort;
        forever begin
            @(posedge clk); #1;
            if (rst_n && req && lut_index != hold_idx) begin
                abort = 0;
                for (int k = 1; k < ack_delay; k++) begin
                    @(posedge clk); #1;
                    if (!req || !rst_n) begin
                        abort = 1;
                        break;
                    end
                end
                if (!abort) begin
                    if (both_left > 0 && lut_index == both_idx) begin
                        ack = 1'b1;
                        nack = 1'b1;
                        both_left--;
                    end else if (lut_index == nack_idx &&
                                 (nack_forever || nack_left > 0)) begin
                        nack = 1'b1;
                        if (nack_left > 0) nack_left--;
                    end else begin
                        ack = 1'b1;
                    end
                    @(posedge clk); #1;
                    ack = 1'b0;
                    nack = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        w_idx.delete();
        w_word.delete();
        min_gap = 1000;
        had_fall = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done || err) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({req, busy, done, err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {req, busy, done, err});
        end
        vectors++;
        if (lut_index !== 8'd2) begin
            miscompares++;
            $display("FAIL reset_index: got %0d want 2", lut_index);
        end
        vectors++;
        if ({dev_addr, reg_addr, reg_data} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_addr: got %h want 0", {dev_addr, reg_addr, reg_data});
        end
        vectors++;
        if (err_index !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_err_index: got %0d want 0", err_index);
        end
        vectors++;
        if ({b_req, b_busy, b_done, b_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_empty: got %b want 0000", {b_req, b_busy, b_done, b_err});
        end
    endtask

    task automatic test_basic();
        logic [23:0] exp [4];
        bit ok;
        exp = '{24'h421280, 24'h420CD0, 24'h421100, 24'h421246};
        clear_log();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL auto_start_busy: got %b want 1", busy);
        end
        wait_done(600, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_timeout: got no done want done");
        end
        vectors++;
        if (w_word.size() != 4) begin
            miscompares++;
            $display("FAIL basic_count: got %0d want 4", w_word.size());
        end
        for (int i = 0; i < 4 && i < w_word.size(); i++) begin
            vectors++;
            if (w_word[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL basic_write%0d: got %h want %h", i, w_word[i], exp[i]);
            end
        end
        vectors++;
        if ({done, busy, err} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_status: got %b want 100", {done, busy, err});
        end
        repeat (30) tick();
        vectors++;
        if (w_word.size() != 4 || lut_index !== 8'd5) begin
            miscompares++;
            $display("FAIL basic_idle: got %0d writes idx %0d want 4 idx 5",
                     w_word.size(), lut_index);
        end
    endtask

    task automatic test_delay();
        logic [23:0] exp [3];
        bit ok;
        exp = '{24'h421280, 24'h421100, 24'h421246};
        lut_mem[3] = 16'hFF02;
        clear_log();
        pulse_start();
        vectors++;
        if ({busy, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL restart_status: got %b want 10", {busy, done});
        end
        wait_done(600, ok);
        vectors++;
        if (!ok || done !== 1'b1) begin
            miscompares++;
            $display("FAIL delay_done: got %b want 1", done);
        end
        vectors++;
        if (w_word.size() != 3) begin
            miscompares++;
            $display("FAIL delay_count: got %0d want 3", w_word.size());
        end
        for (int i = 0; i < 3 && i < w_word.size(); i++) begin
            vectors++;
            if (w_word[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL delay_write%0d: got %h want %h", i, w_word[i], exp[i]);
            end
        end
        // FETCH(3) + DECODE + 20 cycles from DELAY entry to FETCH(4)
        vectors++;
        if (chg_cyc[4] - chg_cyc[3] != 22) begin
            miscompares++;
            $display("FAIL delay_span: got %0d want 22", chg_cyc[4] - chg_cyc[3]);
        end
    endtask

    task automatic test_end_marker();
        bit ok;
        lut_mem[3] = 16'h0CD0;
        lut_mem[4] = 16'hFFFF;
        slave_addr = 8'h60;
        clear_log();
        pulse_start();
        wait_done(600, ok);
        vectors++;
        if (!ok || done !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL end_done: got done %b err %b want 1 0", done, err);
        end
        vectors++;
        if (w_word.size() != 2) begin
            miscompares++;
            $display("FAIL end_count: got %0d want 2", w_word.size());
        end else begin
            vectors++;
            if (w_word[0] !== 24'h601280 || w_word[1] !== 24'h600CD0) begin
                miscompares++;
                $display("FAIL end_writes: got %h %h want 601280 600cd0",
                         w_word[0], w_word[1]);
            end
        end
        repeat (10) tick();
        vectors++;
        if (lut_index !== 8'd4) begin
            miscompares++;
            $display("FAIL end_index: got %0d want 4", lut_index);
        end
        lut_mem[4] = 16'h1100;
        slave_addr = 8'h42;
    endtask

    task automatic test_nack_retry();
        bit ok;
        int n3;
        nack_idx = 8'd3;
        nack_left = 2;
        clear_log();
        pulse_start();
        wait_done(800, ok);
        n3 = 0;
        foreach (w_idx[i]) if (w_idx[i] == 8'd3) n3++;
        vectors++;
        if (n3 != 3 || w_idx.size() != 6) begin
            miscompares++;
            $display("FAIL retry_count: got %0d idx3 %0d total want 3 6", n3, w_idx.size());
        end
        vectors++;
        if (min_gap < 1) begin
            miscompares++;
            $display("FAIL retry_gap: got %0d want >=1", min_gap);
        end
        vectors++;
        if (!ok || {done, err} !== 2'b10) begin
            miscompares++;
            $display("FAIL retry_status: got %b want 10", {done, err});
        end
        nack_idx = 8'hFF;
    endtask

    task automatic test_nack_fail();
        bit ok;
        int n3;
        nack_idx = 8'd3;
        nack_forever = 1;
        clear_log();
        pulse_start();
        wait_done(800, ok);
        n3 = 0;
        foreach (w_idx[i]) if (w_idx[i] == 8'd3) n3++;
        vectors++;
        if (n3 != 4 || w_idx.size() != 5) begin
            miscompares++;
            $display("FAIL fail_attempts: got %0d idx3 %0d total want 4 5", n3, w_idx.size());
        end
        vectors++;
        if (!ok || {err, done, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL fail_status: got %b want 100", {err, done, busy});
        end
        vectors++;
        if (err_index !== 8'd3) begin
            miscompares++;
            $display("FAIL fail_index: got %0d want 3", err_index);
        end
        nack_forever = 0;
        nack_idx = 8'hFF;
        clear_log();
        pulse_start();
        vectors++;
        if ({err, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL rerun_clear: got %b want 01", {err, busy});
        end
        wait_done(600, ok);
        vectors++;
        if (!ok || {done, err} !== 2'b10 || w_idx.size() != 4) begin
            miscompares++;
            $display("FAIL rerun_status: got %b %0d writes want 10 4", {done, err}, w_idx.size());
        end else begin
            vectors++;
            if (w_idx[0] !== 8'd2 || w_idx[3] !== 8'd5) begin
                miscompares++;
                $display("FAIL rerun_order: got %0d..%0d want 2..5", w_idx[0], w_idx[3]);
            end
        end
    endtask

    task automatic test_both();
        bit ok;
        int n2;
        both_idx = 8'd2;
        both_left = 1;
        clear_log();
        pulse_start();
        wait_done(800, ok);
        n2 = 0;
        foreach (w_idx[i]) if (w_idx[i] == 8'd2) n2++;
        vectors++;
        if (n2 != 2 || w_idx.size() != 5) begin
            miscompares++;
            $display("FAIL both_nack_wins: got %0d idx2 %0d total want 2 5", n2, w_idx.size());
        end
        vectors++;
        if (!ok || {done, err} !== 2'b10) begin
            miscompares++;
            $display("FAIL both_status: got %b want 10", {done, err});
        end
        both_idx = 8'hFF;
    endtask

    task automatic test_start_busy();
        bit ok;
        clear_log();
        pulse_start();
        for (int i = 0; i < 100 && w_idx.size() == 0; i++) tick();
        pulse_start();
        repeat (20) tick();
        pulse_start();
        wait_done(600, ok);
        vectors++;
        if (!ok || w_idx.size() != 4) begin
            miscompares++;
            $display("FAIL busy_start: got %0d writes want 4", w_idx.size());
        end else begin
            vectors++;
            if ({w_idx[0], w_idx[1], w_idx[2], w_idx[3]} !== 32'h02030405) begin
                miscompares++;
                $display("FAIL busy_order: got %h want 02030405",
                         {w_idx[0], w_idx[1], w_idx[2], w_idx[3]});
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        hold_idx = 8'd4;
        clear_log();
        pulse_start();
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (req && lut_index == 8'd4) begin
                ok = 1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL mid_reach_wait: got no req on idx4 want req");
        end
        tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if ({req, busy} !== 2'b00 || lut_index !== 8'd2) begin
            miscompares++;
            $display("FAIL mid_reset: got req %b busy %b idx %0d want 0 0 2",
                     req, busy, lut_index);
        end
        vectors++;
        if ({dev_addr, reg_addr, reg_data} !== 24'h0) begin
            miscompares++;
            $display("FAIL mid_reset_addr: got %h want 0", {dev_addr, reg_addr, reg_data});
        end
        hold_idx = 8'hFF;
        clear_log();
        rst_n = 1'b1;
        wait_done(600, ok);
        vectors++;
        if (!ok || done !== 1'b1 || w_idx.size() != 4) begin
            miscompares++;
            $display("FAIL mid_autorun: got done %b %0d writes want 1 4", done, w_idx.size());
        end
    endtask

    task automatic test_empty_table();
        repeat (5) tick();
        vectors++;
        if ({b_busy, b_done, b_req} !== 3'b000) begin
            miscompares++;
            $display("FAIL empty_no_auto: got %b want 000", {b_busy, b_done, b_req});
        end
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        vectors++;
        if ({b_done, b_busy, b_req} !== 3'b100) begin
            miscompares++;
            $display("FAIL empty_done: got %b want 100", {b_done, b_busy, b_req});
        end
        repeat (5) tick();
        vectors++;
        if ({b_done, b_req, b_index} !== {2'b10, 8'd2}) begin
            miscompares++;
            $display("FAIL empty_hold: got %b %0d want 10 2", {b_done, b_req}, b_index);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) lut_mem[i] = 16'hFFFF;
        lut_mem[2] = 16'h1280;
        lut_mem[3] = 16'h0CD0;
        lut_mem[4] = 16'h1100;
        lut_mem[5] = 16'h1246;
        for (int i = 0; i < 16; i++) chg_cyc[i] = 0;
        test_reset();
        test_basic();
        test_delay();
        test_end_marker();
        test_nack_retry();
        test_nack_fail();
        test_both();
        test_start_busy();
        test_reset_mid();
        test_empty_table();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sccb_reg_sequencer.md
Name: sccb_reg_sequencer

Overview:
Parametrised camera-register configuration engine. It walks a combinational register LUT (LUT_INDEX -> LUT_DATA = {reg_addr, reg_data}) and issues one SCCB write per entry through a req/ack handshake to the existing SCCB master. It adds delay entries, early end-of-table, NACK retry, error reporting and software restart. It sits between the per-sensor regData LUT and the SCCB master, and is instantiated once per camera channel.

Parameters:
INDEX_W, 8, width of LUT_INDEX
LUT_BASE, 2, first LUT index executed
LUT_SIZE, 4, number of entries executed (LUT_BASE .. LUT_BASE+LUT_SIZE-1)
TICKS_PER_MS, 25000, iCLK cycles per millisecond for delay entries
MAX_RETRY, 3, re-attempts after a NACK before failing
AUTO_START, 1, 1 = start sequence automatically on reset release

Ports:
iCLK  in  1  system clock
iRST_N  in  1  synchronous active-low reset
iSTART  in  1  single-cycle pulse; (re)runs the sequence from LUT_BASE
iSLAVE_ADDR  in  8  SCCB device write address (e.g. 8'h42)
LUT_INDEX  out  INDEX_W  index presented to the register LUT
LUT_DATA  in  16  LUT word for LUT_INDEX (combinational, valid same cycle)
oREQ  out  1  write request to SCCB master
oDEV_ADDR  out  8  device address for current write
oREG_ADDR  out  8  register address (LUT_DATA[15:8])
oREG_DATA  out  8  register data (LUT_DATA[7:0])
iACK  in  1  one-cycle pulse: write completed, slave acked
iNACK  in  1  one-cycle pulse: write completed with NACK
oBUSY  out  1  high from start until DONE/FAIL
oDONE  out  1  level, sequence completed successfully
oERR  out  1  level, sequence aborted after retries exhausted
oERR_INDEX  out  INDEX_W  LUT index of failing entry

Behaviour:
- Single clock iCLK; reset is synchronous and active-low (iRST_N sampled on rising iCLK edge).
- Reset values: LUT_INDEX=LUT_BASE, oREQ=0, oDEV_ADDR/oREG_ADDR/oREG_DATA=0, oBUSY=0, oDONE=0, oERR=0, oERR_INDEX=0, retry and delay counters=0, state=IDLE.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, NEXT, DONE, FAIL.
- IDLE: if AUTO_START, go to FETCH on the first cycle after reset release; otherwise wait for iSTART. oBUSY=1 from FETCH onward.
- FETCH: drive LUT_INDEX; go to DECODE next cycle.
- DECODE: latch LUT_DATA. Decode as follows:
  - 16'hFFFF: end marker; go to DONE.
  - 16'hFFnn with nn!=FF: delay of nn ms; go to DELAY (nn=0: go straight to NEXT).
  - Any other value: latch oREG_ADDR=LUT_DATA[15:8], oREG_DATA=LUT_DATA[7:0], oDEV_ADDR=iSLAVE_ADDR; go to ISSUE.
- ISSUE: assert oREQ; go to WAIT.
- WAIT: hold oREQ=1 and all address/data outputs stable until iACK or iNACK is sampled high. oREQ falls on the following edge.
  - iACK only: clear retry count; go to NEXT.
  - iNACK (including iACK and iNACK in the same cycle, where NACK wins):
    - retry count < MAX_RETRY: increment it, hold oREQ low for one idle cycle, go to ISSUE.
    - otherwise: oERR_INDEX=LUT_INDEX; go to FAIL.
- DELAY: count TICKS_PER_MS*nn cycles, then go to NEXT. Counter width is clog2(TICKS_PER_MS*255+1).
- NEXT: if LUT_INDEX==LUT_BASE+LUT_SIZE-1, go to DONE; else LUT_INDEX+1, go to FETCH. No wrap-around past the table end.
- DONE: oDONE=1, oBUSY=0. FAIL: oERR=1, oBUSY=0.
- iSTART handling:
  - In IDLE, DONE or FAIL: clear oDONE, oERR and retry count; LUT_INDEX=LUT_BASE; go to FETCH.
  - While oBUSY: ignored.
- iACK/iNACK outside WAIT: ignored.
- Reset mid-operation: all state returns to reset values on that edge, including oREQ=0 and an abandoned delay. The SCCB master is responsible for aborting its own transfer.
- LUT_SIZE=0: go directly to DONE with no transactions.

Test Plan:
- LUT model: idx2=16'h1280, idx3=16'h0CD0, idx4=16'h1100, idx5=16'h1246; AUTO_START=1; ack each req after 10 cycles -> four writes with (42,12,80), (42,0C,D0), (42,11,00), (42,12,46) in order; oDONE=1, oBUSY=0, no fifth oREQ.
- Same table with idx3=16'hFF02, TICKS_PER_MS=10 -> exactly 20 cycles between DELAY entry and next FETCH; three writes total; oDONE=1.
- idx4=16'hFFFF -> writes for idx2 and idx3 only; oDONE=1; LUT_INDEX stops at 4.
- NACK idx3 twice then ACK, MAX_RETRY=3 -> idx3 issued 3 times with ≥1 idle cycle between oREQ pulses; sequence completes, oERR=0.
- NACK idx3 always -> 4 attempts; oERR=1, oERR_INDEX=3, oDONE=0. Then iSTART with acks -> full rerun from idx2, oERR cleared, oDONE=1.
- iRST_N low during WAIT on idx4 -> next edge oREQ=0, LUT_INDEX=2. iACK and iNACK in the same cycle -> treated as NACK. iSTART while busy -> no effect.
